feistel_iter_engine: RTL and testbench

Iterative, parametrised Feistel cipher core: a single round datapath reused over ROUNDS clock cycles instead of an unrolled round chain. It adds a loadable subkey register file, per-block encrypt/decrypt mode (reversed key order), and valid/ready handshakes on input and output. The round function F is external and combinational (the DES f-function block in production). Initial and final permutations stay outside this block, so it sits between the initial permutation and the reverse permutation.

---
 rtl/feistel_iter_engine.sv | 105 ++++++++++
 tb/tb_feistel_iter_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/feistel_iter_engine.sv
// rtl/feistel_iter_engine.sv - iterative Feistel core, one round per cycle, external F
// Sits between the initial and reverse permutations; the subkey file is written only while idle.
module feistel_iter_engine #(
    parameter int WIDTH  = 64,
    parameter int ROUNDS = 16,
    parameter int KEY_W  = 48,
    parameter int AW     = $clog2(ROUNDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_decrypt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 key_we,
    input  logic [AW-1:0]        key_addr,
    input  logic [KEY_W-1:0]     key_wdata,
    output logic                 key_err,
    output logic [WIDTH/2-1:0]   f_r,
    output logic [KEY_W-1:0]     f_key,
    input  logic [WIDTH/2-1:0]   f_out,
    output logic                 busy
);
    localparam int HALF = WIDTH / 2;
    localparam logic [AW:0]   ROUNDS_W = (AW+1)'(ROUNDS);
    localparam logic [AW-1:0] LAST     = AW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [HALF-1:0]   l_q, r_q;
    logic [AW-1:0]     cnt_q;
    logic [AW-1:0]     k_idx;
    logic              mode_q;
    logic              key_err_q;
    logic [KEY_W-1:0]  key_q [ROUNDS];
    logic              accept;
    logic              last_round;
    logic              key_ok;
    logic              key_bad;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_round = (state_q == RUN) && (cnt_q == LAST);
    assign key_ok     = key_we && (state_q == IDLE) && ({1'b0, key_addr} < ROUNDS_W);
    assign key_bad    = key_we && !key_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_round) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // The counter parks on the last round so k_idx stays in range for non-power-of-2 ROUNDS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            l_q    <= in_data[WIDTH-1:HALF];
            r_q    <= in_data[HALF-1:0];
            cnt_q  <= '0;
            mode_q <= in_decrypt;
        end else if (state_q == RUN) begin
            l_q <= r_q;
            r_q <= l_q ^ f_out;
            if (!last_round) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROUNDS; i++) key_q[i] <= '0;
        end else if (key_ok) begin
            key_q[key_addr] <= key_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_err_q <= 1'b0;
        else     key_err_q <= key_bad;
    end

    assign k_idx     = mode_q ? (LAST - cnt_q) : cnt_q;
    assign f_key     = key_q[k_idx];
    assign f_r       = r_q;
    assign out_data  = {r_q, l_q};
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign key_err   = key_err_q;
endmodule

// File: tb/tb_feistel_iter_engine.sv
// tb/tb_feistel_iter_engine.sv - directed bench, ROUNDS=2, F = f_r ^ f_key[31:0]
module tb_feistel_iter_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_decrypt;
    logic [63:0] in_data, out_data;
    logic        out_valid, out_ready;
    logic        key_we, key_err, busy;
    logic [0:0]  key_addr;
    logic [47:0] key_wdata, f_key;
    logic [31:0] f_r, f_out;
    int checks = 0;
    int errors = 0;

    feistel_iter_engine #(.WIDTH(64), .ROUNDS(2), .KEY_W(48), .AW(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_we(key_we), .key_addr(key_addr), .key_wdata(key_wdata), .key_err(key_err),
        .f_r(f_r), .f_key(f_key), .f_out(f_out), .busy(busy)
    );

    assign f_out = f_r ^ f_key[31:0];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_key(input logic addr, input logic [47:0] val);
        key_we = 1'b1; key_addr = addr; key_wdata = val;
        step();
        key_we = 1'b0;
        chk("key_err_idle_write", key_err, 0);
    endtask

    // Accept a block, run both rounds, check latency and result, then release it.
    task automatic run_block(input string tag, input logic [63:0] data, input logic dec,
                             input logic [63:0] exp);
        in_valid = 1'b1; in_data = data; in_decrypt = dec;
        step();
        in_valid = 1'b0; in_data = ~data; in_decrypt = ~dec;
        chk({tag, "_run0_valid"}, out_valid, 0);
        step();
        chk({tag, "_run1_valid"}, out_valid, 0);
        step();
        chk({tag, "_done_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0;
        out_ready = 1'b0; key_we = 1'b0; key_addr = '0; key_wdata = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_f_r", f_r, 0);
        chk("rst_f_key", f_key, 0);
        step(); step();
        rst = 1'b0;
        step();

        write_key(1'b0, 48'h10);
        write_key(1'b1, 48'h100);

        // encrypt, with round-by-round observation of the F interface
        in_valid = 1'b1; in_data = 64'h00000001_00000002; in_decrypt = 1'b0;
        step();
        in_valid = 1'b0;
        chk("enc_busy", busy, 1);
        chk("enc_in_ready", in_ready, 0);
        chk("enc_r0_f_r", f_r, 32'h2);
        chk("enc_r0_f_key", f_key, 48'h10);
        chk("enc_r0_valid", out_valid, 0);
        step();
        chk("enc_r1_f_r", f_r, 32'h13);
        chk("enc_r1_f_key", f_key, 48'h100);
        chk("enc_r1_valid", out_valid, 0);
        step();
        chk("enc_valid", out_valid, 1);
        chk("enc_data", out_data, 64'h00000111_00000013);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("enc_idle", in_ready, 1);

        // decrypt round trip, keys in reverse order
        in_valid = 1'b1; in_data = 64'h00000111_00000013; in_decrypt = 1'b1;
        step();
        in_valid = 1'b0; in_decrypt = 1'b0;
        chk("dec_r0_f_key", f_key, 48'h100);
        step();
        chk("dec_r1_f_key", f_key, 48'h10);
        step();
        chk("dec_valid", out_valid, 1);
        chk("dec_data", out_data, 64'h00000001_00000002);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // backpressure: DONE held, a second in_valid is ignored
        in_valid = 1'b1; in_data = 64'h00000001_00000002; in_decrypt = 1'b0;
        step();
        in_data = 64'hDEADBEEF_CAFEF00D;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 64'h00000111_00000013);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle", in_ready, 1);
        chk("bp_valid_low", out_valid, 0);
        step();
        chk("bp_no_accept", busy, 0);

        // key write during RUN is dropped and flagged for one cycle
        in_valid = 1'b1; in_data = 64'h00000001_00000002; in_decrypt = 1'b0;
        step();
        in_valid = 1'b0;
        key_we = 1'b1; key_addr = 1'b0; key_wdata = 48'hFFF;
        step();
        key_we = 1'b0;
        chk("run_write_err", key_err, 1);
        step();
        chk("run_write_err_pulse", key_err, 0);
        chk("run_write_data", out_data, 64'h00000111_00000013);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        run_block("after_drop", 64'h00000001_00000002, 1'b0, 64'h00000111_00000013);

        // key write coincident with acceptance is used by round 0
        in_valid = 1'b1; in_data = 64'h00000001_00000002; in_decrypt = 1'b0;
        key_we = 1'b1; key_addr = 1'b0; key_wdata = 48'h20;
        step();
        in_valid = 1'b0; key_we = 1'b0;
        chk("coinc_f_key", f_key, 48'h20);
        chk("coinc_key_err", key_err, 0);
        step(); step();
        chk("coinc_data", out_data, 64'h00000121_00000023);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset mid-RUN aborts the block and clears the subkey file
        in_valid = 1'b1; in_data = 64'h00000001_00000002; in_decrypt = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        step();
        chk("abort_no_valid", out_valid, 0);
        rst = 1'b0;
        step();
        chk("abort_stays_idle", out_valid, 0);
        run_block("zero_keys", 64'h00000001_00000002, 1'b0, 64'h00000001_00000003);
        write_key(1'b0, 48'h10);
        write_key(1'b1, 48'h100);
        run_block("reloaded", 64'h00000001_00000002, 1'b0, 64'h00000111_00000013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
